// File: rtl/mem_stage.sv
// Pipeline memory-access stage: word load/store on an internal data memory with multi-cycle latency.
// Optional MEM_RANGE_CHECK_EN adds addr_err and suppresses out-of-range accesses instead of wrapping.
module mem_stage #(
  parameter int DATA_W    = 32,
  parameter int DEST_W    = 4,
  parameter int MEM_DEPTH = 64,
  parameter int BASE_ADDR = 1024,
  parameter int LATENCY   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_enable,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [DEST_W-1:0] dest,
  output logic              freeze,
  output logic              wb_enable_out,
  output logic              mem_r_en_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] mem_res_out,
  output logic [DEST_W-1:0] dest_out
`ifdef MEM_RANGE_CHECK_EN
  ,
  output logic              addr_err
`endif
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               access;
  logic               freeze_raw;
  logic               complete;
  logic               in_range;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_idx;
  logic [DATA_W-1:0]  mem_q [MEM_DEPTH];

  logic               wb_enable_q, wb_enable_d;
  logic               mem_r_en_q, mem_r_en_d;
  logic [DATA_W-1:0]  alu_res_q, alu_res_d;
  logic [DATA_W-1:0]  mem_res_q, mem_res_d;
  logic [DEST_W-1:0]  dest_q, dest_d;
  logic               addr_err_q, addr_err_d;

  assign access  = mem_r_en | mem_w_en;
  assign mem_idx = IDX_W'((alu_res - DATA_W'(BASE_ADDR)) >> 2);

`ifdef MEM_RANGE_CHECK_EN
  assign in_range = (alu_res >= DATA_W'(BASE_ADDR)) &&
                    (((alu_res - DATA_W'(BASE_ADDR)) >> 2) < DATA_W'(MEM_DEPTH));
`else
  assign in_range = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    freeze_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && (LATENCY > 1)) begin
          freeze_raw = 1'b1;
          cnt_d      = CNT_W'(LATENCY - 2);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          freeze_raw = 1'b1;
          cnt_d      = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Gating with rst makes the stall drop the instant reset asserts, even with an access on the inputs.
  assign freeze   = freeze_raw & rst;
  assign complete = access & ~freeze;
  assign mem_we   = complete & mem_w_en & in_range & rst;

  always_comb begin
    wb_enable_d = 1'b0;
    mem_r_en_d  = 1'b0;
    alu_res_d   = '0;
    mem_res_d   = '0;
    dest_d      = '0;
    addr_err_d  = 1'b0;
    if (!freeze) begin
      wb_enable_d = wb_enable;
      mem_r_en_d  = mem_r_en;
      alu_res_d   = alu_res;
      dest_d      = dest;
      addr_err_d  = access & ~in_range;
      // A simultaneous store takes priority, so only a pure load returns data.
      if (mem_r_en && !mem_w_en && in_range) begin
        mem_res_d = mem_q[mem_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wb_enable_q <= 1'b0;
      mem_r_en_q  <= 1'b0;
      alu_res_q   <= '0;
      mem_res_q   <= '0;
      dest_q      <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wb_enable_q <= wb_enable_d;
      mem_r_en_q  <= mem_r_en_d;
      alu_res_q   <= alu_res_d;
      mem_res_q   <= mem_res_d;
      dest_q      <= dest_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Data memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= val_rm;
    end
  end

  assign wb_enable_out = wb_enable_q;
  assign mem_r_en_out  = mem_r_en_q;
  assign alu_res_out   = alu_res_q;
  assign mem_res_out   = mem_res_q;
  assign dest_out      = dest_q;

`ifdef MEM_RANGE_CHECK_EN
  assign addr_err = addr_err_q;
`else
  logic unused_addr_err;
  assign unused_addr_err = addr_err_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed table-driven bench for mem_stage, plus hand sequences for reset and reset-mid-store.
// Honours MEM_RANGE_CHECK_EN when the design is built with it.
module tb_mem_stage;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_enable, mem_r_en, mem_w_en;
  logic [31:0] alu_res, val_rm;
  logic [3:0]  dest;
  logic        freeze, wb_enable_out, mem_r_en_out;
  logic [31:0] alu_res_out, mem_res_out;
  logic [3:0]  dest_out;
`ifdef MEM_RANGE_CHECK_EN
  logic        addr_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(
    .DATA_W(32), .DEST_W(4), .MEM_DEPTH(64), .BASE_ADDR(1024), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_enable(wb_enable), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_res(alu_res), .val_rm(val_rm), .dest(dest),
    .freeze(freeze), .wb_enable_out(wb_enable_out), .mem_r_en_out(mem_r_en_out),
    .alu_res_out(alu_res_out), .mem_res_out(mem_res_out), .dest_out(dest_out)
`ifdef MEM_RANGE_CHECK_EN
    , .addr_err(addr_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb;
    logic        mr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] val;
    logic [3:0]  dst;
    logic [31:0] exp_res;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wb, input logic mr, input logic mw,
                              input logic [31:0] alu, input logic [31:0] val,
                              input logic [3:0] dst, input logic [31:0] exp_res,
                              input logic exp_err);
    vec_t v;
    v.wb = wb; v.mr = mr; v.mw = mw; v.alu = alu; v.val = val;
    v.dst = dst; v.exp_res = exp_res; v.exp_err = exp_err;
    return v;
  endfunction

  // Called at a negedge: applies one instruction, holds it through the stall, checks the result.
  task automatic run_vec(input vec_t v, input string tag);
    int stalls = 0;
    bit f;
    bit done = 0;
    int exp_stalls;
    wb_enable = v.wb; mem_r_en = v.mr; mem_w_en = v.mw;
    alu_res = v.alu; val_rm = v.val; dest = v.dst;
    exp_stalls = (v.mr || v.mw) ? LAT - 1 : 0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      f = freeze;
      @(posedge clk);
      @(negedge clk);
      if (f) begin
        stalls++;
        chk({tag, " bubble"}, {30'd0, wb_enable_out, mem_r_en_out}, 32'd0);
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: freeze never dropped within 20 cycles", tag);
    end
    chk({tag, " stalls"},  stalls, exp_stalls);
    chk({tag, " wb_en"},   {31'd0, wb_enable_out}, {31'd0, v.wb});
    chk({tag, " mr_en"},   {31'd0, mem_r_en_out},  {31'd0, v.mr});
    chk({tag, " alu"},     alu_res_out, v.alu);
    chk({tag, " mem_res"}, mem_res_out, v.exp_res);
    chk({tag, " dest"},    {28'd0, dest_out}, {28'd0, v.dst});
`ifdef MEM_RANGE_CHECK_EN
    chk({tag, " addr_err"}, {31'd0, addr_err}, {31'd0, v.exp_err});
`endif
    $display("%s: wb=%0b mr=%0b mw=%0b alu=0x%08h -> mem_res=0x%08h dest=%0d stalls=%0d",
             tag, v.wb, v.mr, v.mw, v.alu, mem_res_out, dest_out, stalls);
  endtask

  initial begin
    vecs.push_back(mk(1, 0, 0, 32'h55,       32'h0,        4'd3,  32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 32'd1032,     32'hDEADBEEF, 4'd0,  32'h0,        0));
    vecs.push_back(mk(1, 1, 0, 32'd1032,     32'h0,        4'd5,  32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 0, 1, 32'd1024,     32'h11111111, 4'd0,  32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 32'd1028,     32'h22222222, 4'd0,  32'h0,        0));
    vecs.push_back(mk(1, 1, 0, 32'd1024,     32'h0,        4'd1,  32'h11111111, 0));
    vecs.push_back(mk(1, 1, 0, 32'd1028,     32'h0,        4'd2,  32'h22222222, 0));
    vecs.push_back(mk(0, 1, 1, 32'd1040,     32'h44444444, 4'd7,  32'h0,        0));
    vecs.push_back(mk(1, 1, 0, 32'd1040,     32'h0,        4'd8,  32'h44444444, 0));
`ifdef MEM_RANGE_CHECK_EN
    vecs.push_back(mk(0, 0, 1, 32'd1280,     32'h33333333, 4'd0,  32'h0,        1));
    vecs.push_back(mk(1, 1, 0, 32'd1024,     32'h0,        4'd9,  32'h11111111, 0));
    vecs.push_back(mk(1, 1, 0, 32'd1000,     32'h0,        4'd10, 32'h0,        1));
    vecs.push_back(mk(1, 1, 0, 32'd1025,     32'h0,        4'd11, 32'h11111111, 0));
`else
    vecs.push_back(mk(0, 0, 1, 32'd1280,     32'h33333333, 4'd0,  32'h0,        0));
    vecs.push_back(mk(1, 1, 0, 32'd1024,     32'h0,        4'd9,  32'h33333333, 0));
    vecs.push_back(mk(1, 1, 0, 32'd1025,     32'h0,        4'd11, 32'h33333333, 0));
`endif
    vecs.push_back(mk(1, 0, 0, 32'hCAFEF00D, 32'h0,        4'd15, 32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 32'd1036,     32'hA5A5A5A5, 4'd0,  32'h0,        0));

    rst = 1'b0;
    wb_enable = 0; mem_r_en = 0; mem_w_en = 0;
    alu_res = 0; val_rm = 0; dest = 0;

    // Reset held with random inputs: everything quiet.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wb_enable = 1'($urandom); mem_r_en = 1'($urandom); mem_w_en = 1'($urandom);
      alu_res = $urandom; val_rm = $urandom; dest = 4'($urandom);
      #1;
      chk("reset freeze", {31'd0, freeze}, 32'd0);
      chk("reset outs", {29'd0, wb_enable_out, mem_r_en_out, |dest_out}, 32'd0);
      chk("reset data", alu_res_out | mem_res_out, 32'd0);
      $display("reset cycle %0d: freeze=%0b wb_out=%0b alu_out=0x%08h", i, freeze, wb_enable_out, alu_res_out);
    end

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during the 2nd freeze cycle of a store: the store must be abandoned.
    wb_enable = 0; mem_r_en = 0; mem_w_en = 1;
    alu_res = 32'd1036; val_rm = 32'h12345678; dest = 0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mid-store freeze before reset", {31'd0, freeze}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid-store freeze drops", {31'd0, freeze}, 32'd0);
    chk("mid-store outs cleared", {31'd0, wb_enable_out}, 32'd0);
    $display("reset mid-store: freeze=%0b", freeze);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_vec(mk(1, 1, 0, 32'd1036, 32'h0, 4'd6, 32'hA5A5A5A5, 0), "load-after-reset");

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline memory-access stage. Sits between the execute stage and write-back.
- Takes the execute result, store data and control bits, and performs a word load or store on an internal data memory with configurable access latency.
- Stalls the upstream pipeline while an access is pending.
- Registers the MEM/WB payload (alu_res, mem_res, dest, wb_enable, mem_r_en) for the write-back stage to consume.

Parameters:
- DATA_W, 32, data and address word width; equals `REGISTER_FILE_LEN.
- DEST_W, 4, destination register address width; equals `REGISTER_FILE_ADDRESS_LEN.
- MEM_DEPTH, 64, number of 32-bit words in the data memory (power of two).
- BASE_ADDR, 1024, byte address mapped to word 0.
- LATENCY, 4, cycles per memory access (>=1).

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, asynchronous active-low reset.
- wb_enable, input, 1, instruction writes the register file.
- mem_r_en, input, 1, load.
- mem_w_en, input, 1, store.
- alu_res, input, DATA_W, ALU result / byte address.
- val_rm, input, DATA_W, store data.
- dest, input, DEST_W, destination register.
- freeze, output, 1, combinational stall request to IF/ID/EXE.
- wb_enable_out, output, 1, registered to WB.
- mem_r_en_out, output, 1, registered to WB (selects mem_res_out).
- alu_res_out, output, DATA_W, registered to WB.
- mem_res_out, output, DATA_W, registered load data.
- dest_out, output, DEST_W, registered to WB.

Behaviour:
- Reset (rst=0, async):
  - State IDLE, counter 0.
  - All registered outputs 0; freeze=0.
  - Memory contents are not reset.
- Word index = (alu_res - BASE_ADDR) >> 2; alu_res[1:0] ignored. Index is taken modulo MEM_DEPTH unless the optional feature is compiled in.
- Access = mem_r_en | mem_w_en. If both are set, the store wins and mem_res_out is 0.
- FSM states are IDLE and BUSY:
  - IDLE, no access: freeze=0.
  - IDLE, access with LATENCY=1: freeze=0; access completes this cycle; stay IDLE.
  - IDLE, access with LATENCY>1: freeze=1; counter := LATENCY-2; next state BUSY.
  - BUSY, counter>0: freeze=1; counter decrements.
  - BUSY, counter=0: freeze=0; access completes; next state IDLE.
- Access completion (the edge where freeze=0 and an access is present):
  - Store writes val_rm to mem[index].
  - Load captures mem[index] into mem_res_out.
- Resulting timing:
  - freeze is high for exactly LATENCY-1 consecutive cycles per access.
  - Result is visible at the outputs LATENCY cycles after the request first appears.
- Upstream holds all inputs stable while freeze=1. The block relies on this and does not re-latch inputs.
- Output register, every rising edge:
  - freeze=0: wb_enable_out, mem_r_en_out, alu_res_out and dest_out load their inputs. mem_res_out loads the read data for a load, else holds 0.
  - freeze=1: insert a bubble. wb_enable_out=0 and mem_r_en_out=0; data outputs are don't-care (drive 0). WB therefore never writes twice.
- Non-memory instruction: 1-cycle registered pass-through, no stall.
- Back-to-back accesses: a new access in IDLE on the cycle after completion restarts the FSM immediately. No dead cycle.
- Read-after-write to the same word in consecutive instructions: the load returns the newly stored value.
- Reset asserted mid-access: the access is abandoned (a store is not performed), FSM returns to IDLE, freeze drops asynchronously.

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- Defined:
  - Adds output addr_err (1 bit, registered, reset 0).
  - An access with alu_res < BASE_ADDR or index >= MEM_DEPTH still takes full LATENCY.
  - On completion, an out-of-range store is suppressed, a load returns 0, and addr_err pulses high for one cycle alongside the registered outputs.
- Undefined: no addr_err port; index wraps modulo MEM_DEPTH.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 with random inputs.
  - Required response: all outputs 0, freeze=0.
  - Stimulus: release rst.
  - Required response: a non-memory instruction (wb_enable=1, alu_res=0x55, dest=3) appears at the outputs after 1 cycle.
- Store then load, LATENCY=4:
  - Stimulus: store val_rm=0xDEADBEEF at alu_res=1032.
  - Required response: freeze high 3 cycles, wb_enable_out=0 during the stall.
  - Stimulus: then load from 1032 with dest=5.
  - Required response: freeze high 3 cycles; then mem_res_out=0xDEADBEEF, mem_r_en_out=1, dest_out=5 for exactly one cycle.
- Bubble check: during every freeze cycle wb_enable_out=0 and mem_r_en_out=0; WB sees exactly one writeback per instruction.
- Back-to-back loads at 1024 and 1028:
  - Required response: freeze pattern 1,1,1,0,1,1,1,0; results appear in order.
- Reset mid-store:
  - Stimulus: assert rst during the 2nd freeze cycle of a store of 0x12345678 to 1036.
  - Required response: a later load from 1036 does not return 0x12345678 (mem pre-loaded with 0xA5A5A5A5 returns 0xA5A5A5A5).
- With MEM_RANGE_CHECK_EN:
  - Stimulus: load from alu_res=1000.
  - Required response: mem_res_out=0, addr_err=1 for one cycle.
  - Stimulus: store to 1024+4*MEM_DEPTH.
  - Required response: no memory word changes.
  - Without the macro: the same store lands in word 0.
